alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (>= 2).
REQ-002 The block SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, >= 2).
REQ-003 The block SHALL have parameter TAG_W, default 4, width of the opaque command tag.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1; reset is synchronous and active-high.
REQ-006 Port in_valid, input, 1, command present.
REQ-007 Port in_ready, output, 1, stage can accept a command.
REQ-008 Ports in_a and in_b, input, WIDTH each, operands.
REQ-009 Port in_op, input, 3, opcode: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110, SRA 111.
REQ-010 Port in_tag, input, TAG_W, returned unchanged with the result.
REQ-011 Port out_valid, output, 1, result present.
REQ-012 Port out_ready, input, 1, consumer accepts the result.
REQ-013 Port out_y, output, WIDTH, result.
REQ-014 Port out_flags, output, 4, {overflow, carry, zero, negative}.
REQ-015 Port out_tag, output, TAG_W, tag of the result.
REQ-016 Port count, output, clog2(DEPTH)+1, FIFO occupancy.
REQ-017 Port ovf_sticky, output, 1, set by any delivered result with overflow=1.
REQ-018 Port ovf_clr, input, 1, clears ovf_sticky.

Function
REQ-019 Input transfer SHALL occur on an edge where in_valid && in_ready; output transfer on an edge where out_valid && out_ready.
REQ-020 in_ready SHALL equal (count < DEPTH) && !rst, independent of out_ready and in_valid.
REQ-021 The FIFO SHALL store {a, b, op, tag} in order, with read/write pointers wrapping modulo DEPTH.
REQ-022 The FIFO head SHALL drive the combinational alu instance.
REQ-023 The ALU result and flags SHALL load into the output register when count > 0 && (!out_valid || out_ready), popping the head on the same edge.
REQ-024 Latency SHALL be one cycle: a command accepted at edge N with an empty FIFO and a free output register appears with out_valid=1 after edge N+1.
REQ-025 Sustained throughput SHALL be one result per cycle while out_ready=1.
REQ-026 A simultaneous push and pop SHALL leave count unchanged; count SHALL never exceed DEPTH or drop below 0.
REQ-027 While out_valid && !out_ready, out_y, out_flags and out_tag SHALL hold stable.
REQ-028 out_valid SHALL fall after an output transfer when count == 0.
REQ-029 Arithmetic: ADD/SUB SHALL compute in WIDTH+1 bits; carry = bit WIDTH (borrow for SUB); overflow = signed overflow; logic ops and shifts SHALL give carry=0 and overflow=0.
REQ-030 For shifts, a shift amount b >= WIDTH SHALL saturate to WIDTH-1; SRA SHALL sign-fill.
REQ-031 zero SHALL be (y == 0) and negative SHALL be y[WIDTH-1] for every op.
REQ-032 ovf_sticky SHALL set on an output transfer whose overflow=1.
REQ-033 ovf_clr SHALL clear ovf_sticky, and a same-cycle set SHALL win over clear.

Reset
REQ-034 While rst=1, the block SHALL clear pointers and count to 0, out_valid to 0, out_y/out_flags/out_tag to 0, and ovf_sticky to 0.
REQ-035 Reset asserted mid-operation SHALL discard all queued and held results with no output transfer.
REQ-036 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-037 The opcode localparams and flag bit indices SHALL live in shared package alu_pkg.
REQ-038 The existing combinational alu SHALL be instantiated as the sole sub-module; the FIFO is inline.

Verification
REQ-039 ADD a=0x7F b=0x01, out_ready=1 -> one cycle later out_y=0x80, flags ovf=1 carry=0 zero=0 neg=1, ovf_sticky=1.
REQ-040 SUB a=0x00 b=0x01 -> out_y=0xFF, carry=1, overflow=0, negative=1; SUB 0x05-0x05 -> out_y=0x00, zero=1.
REQ-041 SRA a=0x80 b=9 -> out_y=0xFF; SLL a=0x01 b=200 -> out_y=0x80.
REQ-042 Backpressure: out_ready=0, push 5 tagged commands -> in_ready=0 after 4 accepted into the FIFO plus 1 held in the output register; then out_ready=1 -> tags are returned in order, one per cycle.
REQ-043 Push and pop in the same cycle with count=2 -> count stays 2; pointer wrap exercised over 3*DEPTH commands with no loss or reorder.
REQ-044 rst pulsed with count=3 and out_valid=1 -> next cycle count=0, out_valid=0, ovf_sticky=0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings, flag bit positions and a flag-packing
//               helper for the ALU execute stage and its combinational ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings carried on in_op
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLL = 3'b101;
    localparam logic [2:0] c_OP_SRL = 3'b110;
    localparam logic [2:0] c_OP_SRA = 3'b111;

    // Flag vector layout: {overflow, carry, zero, negative}
    localparam int c_FLAGS_W   = 4;
    localparam int c_FLAG_NEG  = 0;
    localparam int c_FLAG_ZERO = 1;
    localparam int c_FLAG_CRY  = 2;
    localparam int c_FLAG_OVF  = 3;

    // Assemble the flag vector so every producer uses the same bit order
    function automatic logic [c_FLAGS_W-1:0] pack_flags(
        input logic i_ovf,
        input logic i_carry,
        input logic i_zero,
        input logic i_neg
    );
        logic [c_FLAGS_W-1:0] v_flags;
        v_flags                = '0;
        v_flags[c_FLAG_OVF]    = i_ovf;
        v_flags[c_FLAG_CRY]    = i_carry;
        v_flags[c_FLAG_ZERO]   = i_zero;
        v_flags[c_FLAG_NEG]    = i_neg;
        return v_flags;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Purely combinational WIDTH-bit ALU. Arithmetic ops produce
//               carry/borrow and signed overflow; logic ops and shifts report
//               carry=0, overflow=0. Shift amounts >= WIDTH saturate to
//               WIDTH-1.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [2:0]           i_op,
    output logic [WIDTH-1:0]     o_y,
    output logic [c_FLAGS_W-1:0] o_flags
);

    // WIDTH always fits in WIDTH bits for WIDTH >= 2
    localparam logic [WIDTH-1:0] c_WIDTH_V  = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] c_SH_MAX   = WIDTH'(WIDTH - 1);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_shamt;
    logic [WIDTH-1:0] w_y;
    logic             w_carry;
    logic             w_ovf;

    // One extra bit so the top bit is the carry out (ADD) or borrow (SUB)
    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_shamt = (i_b >= c_WIDTH_V) ? c_SH_MAX : i_b;

    // Opcode decode: result plus carry/overflow, which are zero unless arithmetic
    always_comb begin
        w_y     = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (i_op)
            c_OP_ADD: begin
                w_y     = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                // Same-sign operands whose result sign differs
                w_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_y     = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                // Opposite-sign operands whose result sign differs from a
                w_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            c_OP_AND: w_y = i_a & i_b;
            c_OP_OR:  w_y = i_a | i_b;
            c_OP_XOR: w_y = i_a ^ i_b;
            c_OP_SLL: w_y = i_a << w_shamt;
            c_OP_SRL: w_y = i_a >> w_shamt;
            c_OP_SRA: w_y = WIDTH'($signed(i_a) >>> w_shamt);
            default:  w_y = '0;
        endcase
    end

    assign o_y     = w_y;
    assign o_flags = pack_flags(w_ovf, w_carry, (w_y == '0), w_y[WIDTH-1]);

endmodule : alu
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : ALU execute stage. Commands {a, b, op, tag} are queued in an
//               inline DEPTH-entry FIFO; the FIFO head feeds a combinational
//               ALU whose result is captured in a valid/ready output register.
//               A sticky flag records any delivered result that overflowed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [c_FLAGS_W-1:0]     out_flags,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_sticky,
    input  logic                     ovf_clr
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_V = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // FIFO storage (no reset needed: contents are qualified by r_count)
    logic [WIDTH-1:0] r_mem_a   [DEPTH];
    logic [WIDTH-1:0] r_mem_b   [DEPTH];
    logic [2:0]       r_mem_op  [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_y;
    logic [c_FLAGS_W-1:0] r_out_flags;
    logic [TAG_W-1:0]     r_out_tag;
    logic                 r_ovf_sticky;

    logic                 w_in_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_out_xfer;
    logic [WIDTH-1:0]     w_alu_y;
    logic [c_FLAGS_W-1:0] w_alu_flags;

    // Ready depends only on occupancy and reset, never on the output side
    assign w_in_ready = (r_count < c_DEPTH_V) && !rst;
    assign w_push     = in_valid && w_in_ready;
    // Head moves into the output register whenever that register is free or draining
    assign w_pop      = (r_count != '0) && (!r_out_valid || out_ready);
    assign w_out_xfer = r_out_valid && out_ready;

    alu #(
        .WIDTH   (WIDTH)
    ) u_alu (
        .i_a     (r_mem_a[r_rd_ptr]),
        .i_b     (r_mem_b[r_rd_ptr]),
        .i_op    (r_mem_op[r_rd_ptr]),
        .o_y     (w_alu_y),
        .o_flags (w_alu_flags)
    );

    // FIFO write: store the accepted command at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= in_a;
            r_mem_b[r_wr_ptr]   <= in_b;
            r_mem_op[r_wr_ptr]  <= in_op;
            r_mem_tag[r_wr_ptr] <= in_tag;
        end
    end

    // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register: load on pop, hold under backpressure, empty after last transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_flags <= '0;
            r_out_tag   <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_alu_y;
            r_out_flags <= w_alu_flags;
            r_out_tag   <= r_mem_tag[r_rd_ptr];
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky overflow: a delivered overflow beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_out_xfer && r_out_flags[c_FLAG_OVF]) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_y      = r_out_y;
    assign out_flags  = r_out_flags;
    assign out_tag    = r_out_tag;
    assign count      = r_count;
    assign ovf_sticky = r_ovf_sticky;

endmodule : alu_exec_stage
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_stage
// Description : Self-checking bench for alu_exec_stage. Accepted commands push
//               an expected result (from an integer reference model) into a
//               scoreboard queue; a monitor pops and compares on each output
//               transfer. Directed sections cover flags, backpressure,
//               push/pop occupancy, sticky overflow and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    localparam int W     = 8;
    localparam int D     = 4;
    localparam int TW    = 4;
    localparam int FULL  = 1 << W;
    localparam int HALF  = 1 << (W - 1);

    typedef struct {
        logic [W-1:0]  y;
        logic [3:0]    f;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [2:0]    in_op = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_y;
    logic [3:0]    out_flags;
    logic [TW-1:0] out_tag;
    logic [2:0]    count;
    logic          ovf_sticky;
    logic          ovf_clr = 1'b0;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rand_ready = 1'b0;

    alu_exec_stage #(
        .WIDTH (W),
        .DEPTH (D),
        .TAG_W (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_flags  (out_flags),
        .out_tag    (out_tag),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views
    function automatic exp_t model(input int a, input int b, input int op, input int tag);
        exp_t e;
        int   sa, sb, r, sh, y;
        bit   c, v;
        sa = (a >= HALF) ? a - FULL : a;
        sb = (b >= HALF) ? b - FULL : b;
        sh = (b >= W) ? W - 1 : b;
        c  = 1'b0;
        v  = 1'b0;
        y  = 0;
        case (op)
            0: begin r = a + b; c = (r >= FULL); y = r % FULL;
                     v = ((sa + sb) >= HALF) || ((sa + sb) < -HALF); end
            1: begin r = a - b; c = (r < 0); y = (r + FULL) % FULL;
                     v = ((sa - sb) >= HALF) || ((sa - sb) < -HALF); end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: y = (a * (1 << sh)) % FULL;
            6: y = a / (1 << sh);
            default: begin
                r = sa;
                for (int k = 0; k < sh; k++) r = (r < 0) ? -((-r + 1) / 2) : r / 2;
                y = (r + FULL) % FULL;
            end
        endcase
        e.y   = W'(y);
        e.f   = {v, c, (y == 0), (y >= HALF)};
        e.tag = TW'(tag);
        return e;
    endfunction

    // Monitor: every output transfer must match the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mon_unexpected: got tag 0x%0h, expected no output", out_tag);
                end else begin
                    e = sb_q.pop_front();
                    chk("mon_y",     32'(out_y),     32'(e.y));
                    chk("mon_flags", 32'(out_flags), 32'(e.f));
                    chk("mon_tag",   32'(out_tag),   32'(e.tag));
                end
            end
        end
    end

    // Offer one command until accepted; expected result is queued at acceptance
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [TW-1:0] tag);
        int waited = 0;
        bit done   = 1'b0;
        in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(int'(a), int'(b), int'(op), int'(tag)));
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (!done) begin
                if (rand_ready) out_ready = ($urandom_range(0, 1) != 0);
                waited++;
                if (waited > 200) begin
                    fail_now("send_timeout");
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 || out_valid) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 200) begin
                fail_now("drain_timeout");
                break;
            end
        end
    endtask

    // Hold a single result under backpressure and compare it with known constants
    task automatic hold_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2:0] op, input logic [W-1:0] ey, input logic [3:0] ef);
        out_ready = 1'b0;
        send(a, b, op, 4'h9);
        @(posedge clk); #1;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_y"},     32'(out_y),     32'(ey));
        chk({name, "_flags"}, 32'(out_flags), 32'(ef));
        drain();
    endtask

    initial begin
        logic [W-1:0]  hy;
        logic [3:0]    hf;
        logic [TW-1:0] ht;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),   32'd0);
        chk("rst_count",     32'(count),      32'd0);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_out_y",     32'(out_y),      32'd0);
        chk("rst_flags",     32'(out_flags),  32'd0);
        chk("rst_tag",       32'(out_tag),    32'd0);
        chk("rst_sticky",    32'(ovf_sticky), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Signed overflow on ADD, one-cycle latency, sticky set on delivery
        out_ready = 1'b1;
        send(8'h7F, 8'h01, 3'b000, 4'h1);
        @(negedge clk);
        chk("lat_first_valid", 32'(out_valid), 32'd0);
        chk("lat_first_count", 32'(count),     32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("add_y",     32'(out_y),     32'h80);
        chk("add_flags", 32'(out_flags), 32'b1001);
        @(posedge clk); #1;
        chk("sticky_set", 32'(ovf_sticky), 32'd1);
        drain();
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("sticky_clr", 32'(ovf_sticky), 32'd0);

        // Same-cycle set and clear: set wins
        out_ready = 1'b0;
        send(8'h7F, 8'h01, 3'b000, 4'h2);
        @(posedge clk); #1;
        ovf_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
        drain();
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;

        // Borrow, zero and shift saturation
        hold_check("sub_borrow", 8'h00, 8'h01, 3'b001, 8'hFF, 4'b0101);
        hold_check("sub_zero",   8'h05, 8'h05, 3'b001, 8'h00, 4'b0010);
        hold_check("sra_sat",    8'h80, 8'd9,  3'b111, 8'hFF, 4'b0001);
        hold_check("sll_sat",    8'h01, 8'd200, 3'b101, 8'h80, 4'b0001);

        // Backpressure: four queued plus one held, then stream in order
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            send(W'($urandom), W'($urandom), 3'($urandom), TW'(t + 3));
        end
        @(negedge clk);
        chk("bp_count",    32'(count),     32'd4);
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_valid",    32'(out_valid), 32'd1);
        hy = out_y; hf = out_flags; ht = out_tag;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hold_y",     32'(out_y),     32'(hy));
        chk("hold_flags", 32'(out_flags), 32'(hf));
        chk("hold_tag",   32'(out_tag),   32'(ht));
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("bp_stream_valid", 32'(out_valid), 32'd1);
            chk("bp_stream_tag",   32'(out_tag),   32'(t + 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Simultaneous push and pop at count 2
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) send(W'(t), W'(t + 1), 3'b000, TW'(t));
        @(negedge clk);
        chk("pp_pre_count", 32'(count), 32'd2);
        @(posedge clk); #1;
        in_a = 8'h11; in_b = 8'h22; in_op = 3'b100; in_tag = 4'hC;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("pp_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) sb_q.push_back(model(32'h11, 32'h22, 4, 12));
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd2);
        drain();

        // Random traffic with random backpressure, many pointer wraps
        rand_ready = 1'b1;
        for (int i = 0; i < 20 * D; i++) begin
            logic [2:0]   op;
            logic [W-1:0] b;
            op = 3'($urandom);
            b  = (op >= 3'b101 && $urandom_range(0, 1) == 1) ? W'($urandom_range(0, 15)) : W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
            send(W'($urandom), b, op, TW'(i));
        end
        rand_ready = 1'b0;
        drain();

        // Reset mid-operation discards everything
        send(8'h7F, 8'h01, 3'b000, 4'h5);
        drain();
        out_ready = 1'b0;
        for (int t = 0; t < 4; t++) send(W'(t), W'(t), 3'b010, TW'(t));
        @(negedge clk);
        chk("mid_pre_count",  32'(count),      32'd3);
        chk("mid_pre_valid",  32'(out_valid),  32'd1);
        chk("mid_pre_sticky", 32'(ovf_sticky), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("mid_count",    32'(count),      32'd0);
        chk("mid_valid",    32'(out_valid),  32'd0);
        chk("mid_sticky",   32'(ovf_sticky), 32'd0);
        chk("mid_in_ready", 32'(in_ready),   32'd1);
        chk("mid_out_y",    32'(out_y),      32'd0);
        @(posedge clk); #1;

        // Stage still works after the reset
        out_ready = 1'b1;
        send(8'h30, 8'h0F, 3'b011, 4'hE);
        drain();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule : tb_alu_exec_stage
`default_nettype wire
